alu_uart_frontend: RTL and testbench



---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_uart_frontend_timer.sv | 28 ++
 rtl/alu_uart_frontend.sv | 163 ++++++++++++++++
 tb/tb_alu_uart_frontend.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: ALU select codes,
// legal-opcode check and FSM state encoding.
// Optional feature macro: ALU_ZERO_TX_EN (adds the ZSEND/ZWAIT states).
package alu_pkg;

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_SRA  = 4'b0011;
  localparam logic [3:0] SEL_SRL  = 4'b0100;
  localparam logic [3:0] SEL_NOR  = 4'b0101;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_ONES = 4'b0111;
  localparam logic [3:0] SEL_XOR  = 4'b1001;
  localparam logic [3:0] SEL_SLL  = 4'b1011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
`ifdef ALU_ZERO_TX_EN
    WAIT_TX = 3'd5,
    ZSEND   = 3'd6,
    ZWAIT   = 3'd7
`else
    WAIT_TX = 3'd5
`endif
  } state_t;

  // An opcode byte is legal only if its upper nibble is clear and the
  // lower nibble names an operation the ALU implements.
  function automatic logic op_legal(input logic [7:0] op);
    if (op[7:4] != 4'b0000) return 1'b0;
    case (op[3:0])
      SEL_AND, SEL_OR, SEL_ADD, SEL_SRA, SEL_SRL,
      SEL_NOR, SEL_SUB, SEL_ONES, SEL_XOR, SEL_SLL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_frontend_timer.sv
// Inter-byte timeout counter for UART command frames. Counts while enabled,
// restarts on clr or when disabled, flags expiry on the last allowed cycle.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Idle-cycle counter; any received byte or leaving the receive states restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || !en) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  // A byte arriving on the final cycle wins over the timeout
  assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/alu_uart_frontend.sv
// Command front end: assembles A/B/OP frames from the UART receiver, drives
// the external combinational ALU, and returns the sign-extended result byte
// through the UART transmitter.
// Optional feature macro: ALU_ZERO_TX_EN -- also transmits {7'b0, zero} as a
// second byte after the result.
module alu_uart_frontend #(
  parameter int BITS           = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_done_tick,
  input  logic [7:0]      rx_data,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [3:0]      alu_select,
  input  logic [BITS-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy,
  output logic            err
);
  import alu_pkg::*;

  state_t state, state_nx;
  logic   ld_a, ld_b, ld_op, cap, err_d;
  logic   tmr_en, tmr_exp;

  logic signed [BITS-1:0] res_s;
  logic signed [7:0]      res_ext;

  assign res_s   = alu_result;
  assign res_ext = res_s;

`ifdef ALU_ZERO_TX_EN
  logic zero_q, ld_z;
`else
  logic unused_zero;
  assign unused_zero = alu_zero;
`endif

  assign tmr_en = (state == GET_B) || (state == GET_OP);
  assign busy   = (state != IDLE);

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (rx_done_tick),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, load strobes and the tx_start pulse
  always_comb begin
    state_nx = state;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    cap      = 1'b0;
    err_d    = 1'b0;
    tx_start = 1'b0;
`ifdef ALU_ZERO_TX_EN
    ld_z     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_done_tick) begin
          ld_a     = 1'b1;
          state_nx = GET_B;
        end
      end
      GET_B: begin
        if (rx_done_tick) begin
          ld_b     = 1'b1;
          state_nx = GET_OP;
        end else if (tmr_exp) begin
          err_d    = 1'b1;
          state_nx = IDLE;
        end
      end
      GET_OP: begin
        if (rx_done_tick) begin
          if (op_legal(rx_data)) begin
            ld_op    = 1'b1;
            state_nx = EXEC;
          end else begin
            err_d    = 1'b1;
            state_nx = IDLE;
          end
        end else if (tmr_exp) begin
          err_d    = 1'b1;
          state_nx = IDLE;
        end
      end
      EXEC: begin
        cap      = 1'b1;
        err_d    = rx_done_tick;
        state_nx = SEND;
      end
      SEND: begin
        tx_start = 1'b1;
        err_d    = rx_done_tick;
        state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        err_d = rx_done_tick;
        if (tx_done_tick) begin
`ifdef ALU_ZERO_TX_EN
          ld_z     = 1'b1;
          state_nx = ZSEND;
`else
          state_nx = IDLE;
`endif
        end
      end
`ifdef ALU_ZERO_TX_EN
      ZSEND: begin
        tx_start = 1'b1;
        err_d    = rx_done_tick;
        state_nx = ZWAIT;
      end
      ZWAIT: begin
        err_d = rx_done_tick;
        if (tx_done_tick) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Operand/opcode registers, result capture and the registered err pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= 4'b0000;
      tx_data    <= 8'h00;
      err        <= 1'b0;
`ifdef ALU_ZERO_TX_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      err <= err_d;
      if (ld_a)  alu_a      <= rx_data[BITS-1:0];
      if (ld_b)  alu_b      <= rx_data[BITS-1:0];
      if (ld_op) alu_select <= rx_data[3:0];
      if (cap)   tx_data    <= res_ext;
`ifdef ALU_ZERO_TX_EN
      if (cap)   zero_q     <= alu_zero;
      if (ld_z)  tx_data    <= {7'b0000000, zero_q};
`endif
    end
  end

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Self-checking bench for alu_uart_frontend: a behavioural ALU closes the
// loop, a table of frames drives the main function and hand-written
// sequences cover timeout, overrun and reset corner cases.
module tb_alu_uart_frontend;
  localparam int BITS = 8;
  localparam int TMO  = 100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_done_tick = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_done_tick = 1'b0;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [BITS-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_select;
  logic            alu_zero, busy, err;

  always #5 clk = ~clk;

  alu_uart_frontend #(.BITS(BITS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .busy         (busy),
    .err          (err)
  );

  // Behavioural ALU as seen on the board
  always_comb begin
    case (alu_select)
      4'h0:    alu_result = alu_a & alu_b;
      4'h1:    alu_result = alu_a | alu_b;
      4'h2:    alu_result = alu_a + alu_b;
      4'h3:    alu_result = $signed(alu_b) >>> alu_a;
      4'h4:    alu_result = alu_b >> alu_a;
      4'h5:    alu_result = ~(alu_a | alu_b);
      4'h6:    alu_result = alu_a - alu_b;
      4'h7:    alu_result = '1;
      4'h9:    alu_result = alu_a ^ alu_b;
      4'hB:    alu_result = alu_b << alu_a;
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  // Output monitor: records every transmitted byte and counts err pulses
  logic [7:0] obs_q[$];
  int         err_cnt = 0;
  always @(negedge clk) begin
    if (tx_start) obs_q.push_back(tx_data);
    if (err) err_cnt++;
  end

  logic [7:0] exp_q[$];
  int         rd_idx = 0;
  int         compared = 0;
  int         mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic       bad;
    logic [7:0] res;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic wait_compare(input string name);
    logic [7:0] e;
    for (int i = 0; i < 20 && obs_q.size() <= rd_idx; i++) @(negedge clk);
    e = exp_q.pop_front();
    if (obs_q.size() <= rd_idx) begin
      check({name, "_no_tx"}, obs_q.size() - rd_idx, 1);
    end else begin
      check(name, int'(obs_q[rd_idx]), int'(e));
      rd_idx++;
    end
  endtask

  task automatic service(input string name);
    wait_compare(name);
    repeat (2) @(negedge clk);
    pulse_tx_done();
  endtask

  task automatic push_expected(input logic [7:0] res);
    exp_q.push_back(res);
`ifdef ALU_ZERO_TX_EN
    exp_q.push_back({7'b0000000, (res == 8'h00)});
`endif
  endtask

  task automatic service_all(input string name);
    service(name);
`ifdef ALU_ZERO_TX_EN
    service({name, "_zero"});
`endif
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic bad,
                           input logic [7:0] res, input string name);
    int e0;
    e0 = err_cnt;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    if (!bad) begin
      push_expected(res);
      @(negedge clk);
      check({name, "_lat2"}, int'(tx_start), 1);
      check({name, "_sel"}, int'(alu_select), int'(op[3:0]));
      service_all({name, "_data"});
      @(negedge clk);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_err"}, err_cnt, e0);
    end else begin
      repeat (3) @(negedge clk);
      check({name, "_err"}, err_cnt, e0 + 1);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_no_tx"}, obs_q.size(), rd_idx);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 8'h08};
    vecs[1]  = '{8'h02, 8'h80, 8'h03, 1'b0, 8'hE0};
    vecs[2]  = '{8'h07, 8'h07, 8'h06, 1'b0, 8'h00};
    vecs[3]  = '{8'h01, 8'h01, 8'h12, 1'b1, 8'h00};
    vecs[4]  = '{8'h01, 8'h01, 8'h08, 1'b1, 8'h00};
    vecs[5]  = '{8'h0F, 8'hF0, 8'h01, 1'b0, 8'hFF};
    vecs[6]  = '{8'h0C, 8'h0A, 8'h00, 1'b0, 8'h08};
    vecs[7]  = '{8'h0C, 8'h0A, 8'h09, 1'b0, 8'h06};
    vecs[8]  = '{8'h01, 8'h81, 8'h0B, 1'b0, 8'h02};
    vecs[9]  = '{8'h03, 8'hF0, 8'h04, 1'b0, 8'h1E};
    vecs[10] = '{8'h00, 8'h00, 8'h05, 1'b0, 8'hFF};
    vecs[11] = '{8'h01, 8'h02, 8'h0A, 1'b1, 8'h00};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_sel", int'(alu_select), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].bad, vecs[i].res,
                $sformatf("vec%0d", i));

    // Timeout after the first byte
    e0 = err_cnt;
    send_byte(8'h05);
    repeat (90) @(negedge clk);
    check("tmo_busy_before", int'(busy), 1);
    check("tmo_err_before", err_cnt, e0);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    @(negedge clk);
    check("tmo_idle", int'(busy), 0);
    check("tmo_err", err_cnt, e0 + 1);
    run_frame(8'h04, 8'h02, 8'h06, 1'b0, 8'h02, "post_tmo");

    // Byte arriving while waiting for the transmitter is an overrun
    e0 = err_cnt;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h02);
    push_expected(8'h08);
    wait_compare("ovr_data");
    send_byte(8'hAA);
    repeat (2) @(negedge clk);
    check("ovr_err", err_cnt, e0 + 1);
    check("ovr_tx_hold", int'(tx_data), 8'h08);
    check("ovr_busy", int'(busy), 1);
    pulse_tx_done();
`ifdef ALU_ZERO_TX_EN
    service("ovr_zero");
`endif
    @(negedge clk);
    check("ovr_idle", int'(busy), 0);
    check("ovr_one_start", obs_q.size(), rd_idx);

    // rx and tx done in the same WAIT_TX cycle: byte is overrun, not A
    e0 = err_cnt;
    send_byte(8'h0C);
    send_byte(8'h0A);
    send_byte(8'h00);
    push_expected(8'h08);
    wait_compare("both_data");
    repeat (2) @(negedge clk);
    rx_data      = 8'hAA;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
`ifdef ALU_ZERO_TX_EN
    service("both_zero");
`endif
    repeat (2) @(negedge clk);
    check("both_err", err_cnt, e0 + 1);
    check("both_idle", int'(busy), 0);
    run_frame(8'h04, 8'h02, 8'h06, 1'b0, 8'h02, "post_both");

    // Asynchronous reset while waiting for OP
    send_byte(8'h05);
    send_byte(8'h03);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_alu_a", int'(alu_a), 0);
    check("arst_alu_b", int'(alu_b), 0);
    check("arst_sel", int'(alu_select), 0);
    check("arst_tx_data", int'(tx_data), 0);
    check("arst_tx_start", int'(tx_start), 0);
    check("arst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(8'h0C, 8'h0A, 8'h09, 1'b0, 8'h06, "post_rst");

    repeat (5) @(negedge clk);
    check("no_extra_tx", obs_q.size(), rd_idx);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
